i2c_accel_responder: RTL and testbench
======================================

Name: i2c_accel_responder

Overview:
- Synthesizable I2C target (responder) emulating the board G-sensor (ADXL345-style register map) at the far end of the accelerometer I2C master's bus.
- Used on-chip for bring-up and regression when the real sensor is absent: the master's SCLK/SDAT are looped to this block instead of the pins.
- Serves DEVID, POWER_CTL, DATA_FORMAT, INT_SOURCE and six data bytes fed from a sample stream; raises an interrupt on new data.

Parameters:
- I2C_ADDR, 7'h53, 7-bit target address matched after START.
- DEVID, 8'hE5, read-only value at register 0x00.
- SYNC_STAGES, 2, flip-flop depth of the SCL/SDA input synchronizers (min 2).

Ports:
- clk_clk  in  1  system clock; must be >= 20x SCL frequency.
- reset_reset  in  1  asynchronous, active-high reset.
- scl_in  in  1  bus SCL level (asynchronous).
- sda_in  in  1  bus SDA level (asynchronous).
- sda_oe  out  1  1 = pull SDA low (open drain); 0 = release.
- sample_valid  in  1  one-cycle strobe: load sample_x/y/z.
- sample_x  in  16  X axis, two's complement; same format for Y and Z.
- sample_y  in  16  Y axis.
- sample_z  in  16  Z axis.
- int_out  out  1  mirrors INT_SOURCE.DATA_READY (bit 7).
- power_ctl  out  8  current POWER_CTL register (0x2D).
- data_format  out  8  current DATA_FORMAT register (0x31).
- busy  out  1  high from address-matched START until STOP.

Behaviour:
- Reset values: sda_oe=0, int_out=0, power_ctl=0x00, data_format=0x00, busy=0, pointer=0x00, data regs=0, FSM=IDLE. Reset mid-transfer releases SDA immediately.
- Input synchronization: SCL and SDA pass through SYNC_STAGES flops, then edge detect.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high.
- Bits are sampled on the synchronized SCL rising edge, MSB first.
- sda_oe changes only on the first clk after a synchronized SCL falling edge.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, WR_DATA, WR_ACK, RD_DATA, RD_ACK, IGNORE.
  - START from any state -> ADDR with bit count 0. This includes repeated START.
  - STOP from any state -> IDLE, sda_oe=0, busy=0.
  - ADDR: after 8 bits, if addr==I2C_ADDR -> ADDR_ACK and drive ACK low for one SCL period. Otherwise -> IGNORE, which never drives SDA.
  - Write (R/W=0): first byte -> PTR (pointer <= byte[5:0], ACK). Later bytes -> WR_DATA, ACK each, write reg[pointer], pointer++.
  - Read (R/W=1): shift out reg[pointer] from the snapshot on the SCL fall after ACK, pointer++ after each byte.
  - RD_ACK: master ACK (SDA low) -> next byte. Master NACK -> IGNORE until STOP/START.
- Register map:
  - 0x00 DEVID: read-only.
  - 0x2D POWER_CTL and 0x31 DATA_FORMAT: read/write.
  - 0x30 INT_SOURCE: read-only; bit7 DATA_READY.
  - 0x32..0x37 DATAX0,X1,Y0,Y1,Z0,Z1: little-endian, read-only.
  - All other addresses read 0x00; writes to them are ignored and still ACKed.
- Pointer is 6 bits and wraps 0x3F -> 0x00.
- Snapshot: on address match with R/W=1, copy 0x30..0x37 into a shadow used for the whole read burst. sample_valid during the burst updates live registers only, so there is no tearing.
- DATA_READY:
  - Set on sample_valid.
  - Cleared when byte 0x37 has been fully shifted out in a read.
  - If set and clear occur in the same cycle, set wins.
  - int_out is registered, one cycle after the flag.
- busy is asserted in ADDR_ACK on match.

Decomposition:
- Package i2c_accel_pkg: FSM state enum, register address constants (REG_DEVID, REG_INT_SOURCE, REG_POWER_CTL, REG_DATA_FORMAT, REG_DATAX0..REG_DATAZ1), DATA_READY bit index.
- Sub-module i2c_line_sync: synchronizers plus scl_rise, scl_fall, start and stop pulses.

Test Plan:
- DEVID read: START, 0xA6, 0x00, Sr, 0xA7, read 1 byte with NACK, STOP -> byte 0xE5; ACK on all three written bytes; busy high through STOP.
- Write config: START, 0xA6, 0x2D, 0x08, 0x0B (auto-increment to 0x2E, ignored) -> power_ctl=0x08; data_format unchanged at 0x00; 0x2E reads 0x00.
- Burst read with snapshot: sample_valid with x=0x1234, y=0xFFF0, z=0x0100; read 6 bytes from 0x32; inject a second sample mid-burst -> bytes 34 12 F0 FF 00 01; int_out falls after byte 6; int_out high again because of the later sample.
- Wrong address: START, 0xA8 -> sda_oe never asserted; busy stays 0; registers unchanged.
- Pointer wrap: set pointer 0x3F, read 2 bytes -> 0x00 then 0xE5 (DEVID).
- Reset mid-read while driving a 0 bit -> sda_oe=0 within the same cycle; after release, IDLE; next transaction succeeds.

Source files
------------

// File: rtl/i2c_accel_pkg.sv
// Shared types and register map for the on-chip accelerometer I2C responder.
// Holds FSM states, register addresses and the INT_SOURCE byte builder.
package i2c_accel_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    PTR,
    WR_DATA,
    WR_ACK,
    RD_DATA,
    RD_ACK,
    IGNORE
  } i2c_state_e;

  localparam logic [5:0] REG_DEVID       = 6'h00;
  localparam logic [5:0] REG_POWER_CTL   = 6'h2D;
  localparam logic [5:0] REG_INT_SOURCE  = 6'h30;
  localparam logic [5:0] REG_DATA_FORMAT = 6'h31;
  localparam logic [5:0] REG_DATAX0      = 6'h32;
  localparam logic [5:0] REG_DATAX1      = 6'h33;
  localparam logic [5:0] REG_DATAY0      = 6'h34;
  localparam logic [5:0] REG_DATAY1      = 6'h35;
  localparam logic [5:0] REG_DATAZ0      = 6'h36;
  localparam logic [5:0] REG_DATAZ1      = 6'h37;

  localparam int DATA_READY_BIT = 7;

  function automatic logic [7:0] int_source_byte(input logic data_ready);
    logic [7:0] b;
    b = 8'h00;
    b[DATA_READY_BIT] = data_ready;
    return b;
  endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Brings the asynchronous SCL/SDA levels into the clk domain and derives
// SCL edge pulses plus START/STOP condition pulses.
module i2c_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic scl_in,
  input  logic sda_in,
  output logic sda,
  output logic scl_rise,
  output logic scl_fall,
  output logic start,
  output logic stop
);

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_d_r;
  logic                   sda_d_r;
  logic                   scl_s;
  logic                   sda_s;

  assign scl_s = scl_sync_r[SYNC_STAGES-1];
  assign sda_s = sda_sync_r[SYNC_STAGES-1];

  // Synchronizer chains plus one delayed copy for edge detection; idle bus is high
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_sync_r <= '1;
      sda_sync_r <= '1;
      scl_d_r    <= 1'b1;
      sda_d_r    <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_in};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_in};
      scl_d_r    <= scl_s;
      sda_d_r    <= sda_s;
    end
  end

  assign sda      = sda_s;
  assign scl_rise = scl_s & ~scl_d_r;
  assign scl_fall = ~scl_s & scl_d_r;
  assign start    = scl_s & scl_d_r & sda_d_r & ~sda_s;
  assign stop     = scl_s & scl_d_r & ~sda_d_r & sda_s;

endmodule

// File: rtl/i2c_accel_responder.sv
// I2C target emulating an ADXL345-style G-sensor for loopback bring-up.
// Serves ID/config/interrupt/data registers with a per-burst data snapshot.
module i2c_accel_responder
  import i2c_accel_pkg::*;
#(
  parameter logic [6:0] I2C_ADDR    = 7'h53,
  parameter logic [7:0] DEVID       = 8'hE5,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_oe,
  input  logic        sample_valid,
  input  logic [15:0] sample_x,
  input  logic [15:0] sample_y,
  input  logic [15:0] sample_z,
  output logic        int_out,
  output logic [7:0]  power_ctl,
  output logic [7:0]  data_format,
  output logic        busy
);

  logic        sda_s;
  logic        scl_rise_s;
  logic        scl_fall_s;
  logic        start_s;
  logic        stop_s;

  i2c_state_e  state_r, state_nx;
  logic [3:0]  bit_cnt_r, bit_cnt_nx;
  logic        phase_r, phase_nx;
  logic [6:0]  rx_r, rx_nx;
  logic [6:0]  tx_r, tx_nx;
  logic [5:0]  ptr_r, ptr_nx;
  logic        sda_oe_r, oe_nx;
  logic        busy_r, busy_nx;
  logic        rw_r, rw_nx;
  logic        wr_en_s;
  logic        snap_en_s;
  logic        dr_clr_s;
  logic [7:0]  rx_byte_s;
  logic [7:0]  rd_byte_s;

  logic [7:0]  power_ctl_r;
  logic [7:0]  data_format_r;
  logic [47:0] live_r;
  logic [47:0] snap_r;
  logic [7:0]  snap_int_r;
  logic        dr_r;
  logic        int_out_r;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sda      (sda_s),
    .scl_rise (scl_rise_s),
    .scl_fall (scl_fall_s),
    .start    (start_s),
    .stop     (stop_s)
  );

  assign rx_byte_s = {rx_r, sda_s};

  // Read mux: data and INT_SOURCE come from the burst snapshot, config is live
  always_comb begin
    rd_byte_s = 8'h00;
    case (ptr_r)
      REG_DEVID:       rd_byte_s = DEVID;
      REG_POWER_CTL:   rd_byte_s = power_ctl_r;
      REG_INT_SOURCE:  rd_byte_s = snap_int_r;
      REG_DATA_FORMAT: rd_byte_s = data_format_r;
      REG_DATAX0:      rd_byte_s = snap_r[7:0];
      REG_DATAX1:      rd_byte_s = snap_r[15:8];
      REG_DATAY0:      rd_byte_s = snap_r[23:16];
      REG_DATAY1:      rd_byte_s = snap_r[31:24];
      REG_DATAZ0:      rd_byte_s = snap_r[39:32];
      REG_DATAZ1:      rd_byte_s = snap_r[47:40];
      default:         rd_byte_s = 8'h00;
    endcase
  end

  // Protocol FSM next-state and datapath decisions
  always_comb begin
    state_nx   = state_r;
    bit_cnt_nx = bit_cnt_r;
    phase_nx   = phase_r;
    rx_nx      = rx_r;
    tx_nx      = tx_r;
    ptr_nx     = ptr_r;
    oe_nx      = sda_oe_r;
    busy_nx    = busy_r;
    rw_nx      = rw_r;
    wr_en_s    = 1'b0;
    snap_en_s  = 1'b0;
    dr_clr_s   = 1'b0;
    if (start_s) begin
      state_nx   = ADDR;
      bit_cnt_nx = 4'd0;
      phase_nx   = 1'b0;
      oe_nx      = 1'b0;
    end else if (stop_s) begin
      state_nx   = IDLE;
      bit_cnt_nx = 4'd0;
      phase_nx   = 1'b0;
      oe_nx      = 1'b0;
      busy_nx    = 1'b0;
    end else begin
      case (state_r)
        ADDR, PTR, WR_DATA: begin
          if (scl_rise_s) begin
            rx_nx      = rx_byte_s[6:0];
            bit_cnt_nx = bit_cnt_r + 4'd1;
            if (bit_cnt_r == 4'd7) begin
              bit_cnt_nx = 4'd0;
              phase_nx   = 1'b0;
              if (state_r == ADDR) begin
                if (rx_byte_s[7:1] == I2C_ADDR) begin
                  state_nx  = ADDR_ACK;
                  busy_nx   = 1'b1;
                  rw_nx     = rx_byte_s[0];
                  snap_en_s = rx_byte_s[0];
                end else begin
                  state_nx = IGNORE;
                end
              end else if (state_r == PTR) begin
                ptr_nx   = rx_byte_s[5:0];
                state_nx = WR_ACK;
              end else begin
                wr_en_s  = 1'b1;
                ptr_nx   = ptr_r + 6'd1;
                state_nx = WR_ACK;
              end
            end else begin
              phase_nx = phase_r;
            end
          end else begin
            rx_nx = rx_r;
          end
        end
        // First SCL fall starts the ACK, the second ends it
        ADDR_ACK, WR_ACK: begin
          if (scl_fall_s) begin
            if (!phase_r) begin
              oe_nx    = 1'b1;
              phase_nx = 1'b1;
            end else begin
              phase_nx = 1'b0;
              if ((state_r == ADDR_ACK) && rw_r) begin
                tx_nx    = rd_byte_s[6:0];
                oe_nx    = ~rd_byte_s[7];
                state_nx = RD_DATA;
              end else if (state_r == ADDR_ACK) begin
                oe_nx    = 1'b0;
                state_nx = PTR;
              end else begin
                oe_nx    = 1'b0;
                state_nx = WR_DATA;
              end
            end
          end else begin
            phase_nx = phase_r;
          end
        end
        RD_DATA: begin
          if (scl_rise_s) begin
            bit_cnt_nx = bit_cnt_r + 4'd1;
          end else if (scl_fall_s) begin
            if (bit_cnt_r == 4'd8) begin
              oe_nx      = 1'b0;
              bit_cnt_nx = 4'd0;
              ptr_nx     = ptr_r + 6'd1;
              dr_clr_s   = (ptr_r == REG_DATAZ1);
              state_nx   = RD_ACK;
            end else begin
              tx_nx = {tx_r[5:0], 1'b0};
              oe_nx = ~tx_r[6];
            end
          end else begin
            tx_nx = tx_r;
          end
        end
        RD_ACK: begin
          if (scl_rise_s && sda_s) begin
            state_nx = IGNORE;
          end else if (scl_fall_s) begin
            tx_nx    = rd_byte_s[6:0];
            oe_nx    = ~rd_byte_s[7];
            state_nx = RD_DATA;
          end else begin
            tx_nx = tx_r;
          end
        end
        default: begin
          oe_nx = 1'b0;
        end
      endcase
    end
  end

  // FSM and shift-path state registers
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_r   <= IDLE;
      bit_cnt_r <= 4'd0;
      phase_r   <= 1'b0;
      rx_r      <= 7'd0;
      tx_r      <= 7'd0;
      ptr_r     <= 6'd0;
      sda_oe_r  <= 1'b0;
      busy_r    <= 1'b0;
      rw_r      <= 1'b0;
    end else begin
      state_r   <= state_nx;
      bit_cnt_r <= bit_cnt_nx;
      phase_r   <= phase_nx;
      rx_r      <= rx_nx;
      tx_r      <= tx_nx;
      ptr_r     <= ptr_nx;
      sda_oe_r  <= oe_nx;
      busy_r    <= busy_nx;
      rw_r      <= rw_nx;
    end
  end

  // Register file, sample capture, snapshot and DATA_READY (set beats clear)
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      power_ctl_r   <= 8'h00;
      data_format_r <= 8'h00;
      live_r        <= 48'd0;
      snap_r        <= 48'd0;
      snap_int_r    <= 8'h00;
      dr_r          <= 1'b0;
      int_out_r     <= 1'b0;
    end else begin
      if (wr_en_s) begin
        case (ptr_r)
          REG_POWER_CTL:   power_ctl_r   <= rx_byte_s;
          REG_DATA_FORMAT: data_format_r <= rx_byte_s;
          default:         power_ctl_r   <= power_ctl_r;
        endcase
      end
      if (sample_valid) begin
        live_r <= {sample_z, sample_y, sample_x};
      end
      if (snap_en_s) begin
        snap_r     <= live_r;
        snap_int_r <= int_source_byte(dr_r);
      end
      if (sample_valid) begin
        dr_r <= 1'b1;
      end else if (dr_clr_s) begin
        dr_r <= 1'b0;
      end
      int_out_r <= dr_r;
    end
  end

  assign sda_oe      = sda_oe_r;
  assign busy        = busy_r;
  assign power_ctl   = power_ctl_r;
  assign data_format = data_format_r;
  assign int_out     = int_out_r;

endmodule

// File: tb/tb_i2c_accel_responder.sv
// Directed bench: a bit-banged I2C master on an open-drain bus drives the
// responder through register reads/writes, snapshot bursts and reset cases.
module tb_i2c_accel_responder;

  localparam int QCLK = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        m_sda;
  logic        sda_in;
  logic        sda_oe;
  logic        sample_valid;
  logic [15:0] sample_x, sample_y, sample_z;
  logic        int_out;
  logic [7:0]  power_ctl;
  logic [7:0]  data_format;
  logic        busy;

  int checks = 0;
  int failures = 0;

  logic mon_clr;
  logic oe_seen;
  logic busy_seen;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] rexp;
    logic [7:0] pc_exp;
    logic [7:0] df_exp;
  } wr_vec_t;

  wr_vec_t vec [8];

  always #5 clk = ~clk;

  assign sda_in = m_sda & ~sda_oe;

  i2c_accel_responder dut (
    .clk_clk      (clk),
    .reset_reset  (rst),
    .scl_in       (scl),
    .sda_in       (sda_in),
    .sda_oe       (sda_oe),
    .sample_valid (sample_valid),
    .sample_x     (sample_x),
    .sample_y     (sample_y),
    .sample_z     (sample_z),
    .int_out      (int_out),
    .power_ctl    (power_ctl),
    .data_format  (data_format),
    .busy         (busy)
  );

  always @(posedge clk) begin
    if (mon_clr) begin
      oe_seen   <= 1'b0;
      busy_seen <= 1'b0;
    end else begin
      if (sda_oe) oe_seen <= 1'b1;
      if (busy) busy_seen <= 1'b1;
    end
  end

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic q();
    tick(QCLK);
  endtask

  task automatic i2c_start();
    m_sda = 1'b0; q();
    scl = 1'b0; q();
  endtask

  task automatic i2c_rstart();
    m_sda = 1'b1; q();
    scl = 1'b1; q();
    m_sda = 1'b0; q();
    scl = 1'b0; q();
  endtask

  task automatic i2c_stop();
    m_sda = 1'b0; q();
    scl = 1'b1; q();
    m_sda = 1'b1; q();
  endtask

  task automatic wbit(input logic b);
    m_sda = b; q();
    scl = 1'b1; q(); q();
    scl = 1'b0; q();
  endtask

  task automatic rbit(output logic b);
    m_sda = 1'b1; q();
    scl = 1'b1; q();
    b = sda_in; q();
    scl = 1'b0; q();
  endtask

  // exp_level: bus level expected in the ACK slot (0 = ACK, 1 = NACK)
  task automatic wbyte(input logic [7:0] d, input logic exp_level, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) wbit(d[i]);
    m_sda = 1'b1; q();
    scl = 1'b1; q();
    a = sda_in; q();
    scl = 1'b0; q();
    check1(name, a, exp_level);
  endtask

  task automatic rbyte(output logic [7:0] d, input logic nack);
    logic b;
    d = 8'h00;
    for (int i = 0; i < 8; i++) begin
      rbit(b);
      d = {d[6:0], b};
    end
    m_sda = nack; q();
    scl = 1'b1; q(); q();
    scl = 1'b0; q();
  endtask

  task automatic write_reg(input logic [7:0] addr, input logic [7:0] data);
    i2c_start();
    wbyte(8'hA6, 1'b0, "wr_addr_ack");
    wbyte(addr, 1'b0, "wr_ptr_ack");
    wbyte(data, 1'b0, "wr_data_ack");
    i2c_stop();
    q();
  endtask

  task automatic read_reg(input logic [7:0] addr, output logic [7:0] data);
    i2c_start();
    wbyte(8'hA6, 1'b0, "rd_addr_ack");
    wbyte(addr, 1'b0, "rd_ptr_ack");
    i2c_rstart();
    wbyte(8'hA7, 1'b0, "rd_addr_r_ack");
    rbyte(data, 1'b1);
    i2c_stop();
    q();
  endtask

  task automatic pulse_sample(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
    sample_x = x; sample_y = y; sample_z = z;
    sample_valid = 1'b1;
    tick(1);
    sample_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] rd;
    logic       b;

    vec[0] = '{8'h2D, 8'h08, 8'h08, 8'h08, 8'h00};
    vec[1] = '{8'h31, 8'h0B, 8'h0B, 8'h08, 8'h0B};
    vec[2] = '{8'h00, 8'h12, 8'hE5, 8'h08, 8'h0B};
    vec[3] = '{8'h2E, 8'h55, 8'h00, 8'h08, 8'h0B};
    vec[4] = '{8'h3A, 8'hFF, 8'h00, 8'h08, 8'h0B};
    vec[5] = '{8'h2D, 8'h09, 8'h09, 8'h09, 8'h0B};
    vec[6] = '{8'h31, 8'h00, 8'h00, 8'h09, 8'h00};
    vec[7] = '{8'h30, 8'h80, 8'h00, 8'h09, 8'h00};

    rst = 1'b1; scl = 1'b1; m_sda = 1'b1; mon_clr = 1'b1;
    sample_valid = 1'b0; sample_x = 16'h0000; sample_y = 16'h0000; sample_z = 16'h0000;
    tick(3);
    check1("rst_sda_oe", sda_oe, 1'b0);
    check1("rst_int_out", int_out, 1'b0);
    check8("rst_power_ctl", power_ctl, 8'h00);
    check8("rst_data_format", data_format, 8'h00);
    check1("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick(3);

    // DEVID read with repeated START
    i2c_start();
    wbyte(8'hA6, 1'b0, "devid_ack_addr_w");
    wbyte(8'h00, 1'b0, "devid_ack_ptr");
    i2c_rstart();
    wbyte(8'hA7, 1'b0, "devid_ack_addr_r");
    check1("devid_busy_mid", busy, 1'b1);
    rbyte(rd, 1'b1);
    check8("devid_byte", rd, 8'hE5);
    check1("devid_busy_before_stop", busy, 1'b1);
    i2c_stop();
    q();
    check1("devid_busy_after_stop", busy, 1'b0);
    check1("devid_sda_released", sda_oe, 1'b0);

    // Config write with auto-increment into an unmapped register
    i2c_start();
    wbyte(8'hA6, 1'b0, "cfg_ack_addr");
    wbyte(8'h2D, 1'b0, "cfg_ack_ptr");
    wbyte(8'h08, 1'b0, "cfg_ack_d0");
    wbyte(8'h0B, 1'b0, "cfg_ack_d1");
    i2c_stop();
    q();
    check8("cfg_power_ctl", power_ctl, 8'h08);
    check8("cfg_data_format", data_format, 8'h00);
    read_reg(8'h2E, rd);
    check8("cfg_2e_reads_zero", rd, 8'h00);

    // Table of write-then-readback vectors
    for (int i = 0; i < 8; i++) begin
      write_reg(vec[i].addr, vec[i].wdata);
      read_reg(vec[i].addr, rd);
      check8($sformatf("tbl%0d_read", i), rd, vec[i].rexp);
      check8($sformatf("tbl%0d_power_ctl", i), power_ctl, vec[i].pc_exp);
      check8($sformatf("tbl%0d_data_format", i), data_format, vec[i].df_exp);
    end

    // Burst read with snapshot and DATA_READY handling
    pulse_sample(16'h1234, 16'hFFF0, 16'h0100);
    check1("int_out_lag", int_out, 1'b0);
    tick(1);
    check1("int_out_set", int_out, 1'b1);
    read_reg(8'h30, rd);
    check8("int_source_ready", rd, 8'h80);
    i2c_start();
    wbyte(8'hA6, 1'b0, "burst_ack_addr_w");
    wbyte(8'h32, 1'b0, "burst_ack_ptr");
    i2c_rstart();
    wbyte(8'hA7, 1'b0, "burst_ack_addr_r");
    rbyte(rd, 1'b0); check8("burst_x0", rd, 8'h34);
    rbyte(rd, 1'b0); check8("burst_x1", rd, 8'h12);
    pulse_sample(16'hAAAA, 16'hBBBB, 16'hCCCC);
    rbyte(rd, 1'b0); check8("burst_y0", rd, 8'hF0);
    rbyte(rd, 1'b0); check8("burst_y1", rd, 8'hFF);
    rbyte(rd, 1'b0); check8("burst_z0", rd, 8'h00);
    check1("burst_int_before_last", int_out, 1'b1);
    rbyte(rd, 1'b1); check8("burst_z1", rd, 8'h01);
    i2c_stop();
    q();
    check1("burst_int_cleared", int_out, 1'b0);
    read_reg(8'h32, rd);
    check8("live_after_mid_sample", rd, 8'hAA);
    read_reg(8'h30, rd);
    check8("int_source_cleared", rd, 8'h00);
    pulse_sample(16'h5678, 16'h0000, 16'h0000);
    tick(1);
    check1("int_out_reasserted", int_out, 1'b1);

    // Wrong address: responder must stay off the bus
    mon_clr = 1'b1;
    tick(2);
    mon_clr = 1'b0;
    i2c_start();
    wbyte(8'hA8, 1'b1, "wrong_addr_nack");
    wbyte(8'h2D, 1'b1, "wrong_ptr_nack");
    wbyte(8'hFF, 1'b1, "wrong_data_nack");
    i2c_stop();
    q();
    check1("wrong_oe_never", oe_seen, 1'b0);
    check1("wrong_busy_never", busy_seen, 1'b0);
    check8("wrong_power_ctl", power_ctl, 8'h09);
    check8("wrong_data_format", data_format, 8'h00);

    // Pointer wraps from 0x3F to DEVID
    i2c_start();
    wbyte(8'hA6, 1'b0, "wrap_ack_addr_w");
    wbyte(8'h3F, 1'b0, "wrap_ack_ptr");
    i2c_rstart();
    wbyte(8'hA7, 1'b0, "wrap_ack_addr_r");
    rbyte(rd, 1'b0); check8("wrap_3f", rd, 8'h00);
    rbyte(rd, 1'b1); check8("wrap_00", rd, 8'hE5);
    i2c_stop();
    q();

    // Reset while the responder is driving a 0 data bit
    i2c_start();
    wbyte(8'hA6, 1'b0, "rstmid_ack_addr_w");
    wbyte(8'h00, 1'b0, "rstmid_ack_ptr");
    i2c_rstart();
    wbyte(8'hA7, 1'b0, "rstmid_ack_addr_r");
    for (int i = 0; i < 3; i++) begin
      rbit(b);
      check1("rstmid_bit_one", b, 1'b1);
    end
    check1("rstmid_driving_zero", sda_oe, 1'b1);
    rst = 1'b1;
    #1;
    check1("rstmid_sda_released", sda_oe, 1'b0);
    m_sda = 1'b1;
    scl = 1'b1;
    q();
    rst = 1'b0;
    q();
    check1("rstmid_busy", busy, 1'b0);
    check8("rstmid_power_ctl", power_ctl, 8'h00);
    check1("rstmid_int_out", int_out, 1'b0);
    read_reg(8'h00, rd);
    check8("rstmid_next_devid", rd, 8'hE5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
